core_ctrl: RTL
==============

# core_ctrl

Multi-cycle sequencer for the tiny-riscv core. It owns the single shared memory port and alternates it between instruction fetch and load/store data access. It consumes the instruction decoder's classification outputs and generates the strobes for the instruction register, PC, register file and write-back mux. It also counts retired instructions and traps on malformed load/store encodings or memory timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for mem_ready per access; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  memory access request; held until mem_ready
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- mem_we  out  1  store write enable; qualified by mem_req
- mem_ready  in  1  access complete; read data valid this cycle
- ir_we  out  1  latch fetched word into instruction register
- is_alu_op  in  1  from decoder
- is_ls_op  in  1  from decoder
- ls_op  in  ls_op_t  from decoder
- is_br_op  in  1  from decoder
- br_op  in  4  from decoder
- br_taken  in  1  branch unit resolution; JAL/JALR always taken
- rf_we  out  1  register-file write strobe
- wb_sel  out  wb_sel_t  write-back source: WB_ALU, WB_MEM or WB_PC4
- pc_we  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = branch/jump target
- instret  out  32  retired-instruction count
- halted  out  1  core trapped
- trap_cause  out  trap_cause_t  TRAP_NONE, TRAP_ILLEGAL_LS or TRAP_BUS_TIMEOUT

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - Drives mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1 for one cycle, then go to DECODE.
- DECODE: single cycle for decoder and register-file read. Always goes to EXEC.
- EXEC: single cycle for the ALU and branch compare.
  - is_ls_op with ls_op==i_LSNOP: go to TRAP, cause TRAP_ILLEGAL_LS.
  - Other is_ls_op: go to MEM.
  - Anything else: go to WB.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=is_store(ls_op).
  - On mem_ready: go to WB.
- WB (exactly one cycle):
  - pc_we=1.
  - pc_sel = is_br_op & br_taken.
  - instret increments.
  - Then go to FETCH.
- WB rf_we and wb_sel by instruction class:
  - ALU: rf_we=1, wb_sel=WB_ALU.
  - Load: rf_we=1, wb_sel=WB_MEM.
  - Store: rf_we=0. The decoder's reg_we is deliberately not used for this.
  - br_op ∈ {i_JAL, i_JALR}: rf_we=1, wb_sel=WB_PC4.
  - Conditional branch: rf_we=0.
  - Instruction with no class flag (LUI/AUIPC/unknown): rf_we=0, PC+4, still retires.
- TRAP:
  - Sets halted=1 and holds trap_cause.
  - All strobes are 0.
  - Exits only on reset.
- Timeout:
  - A wait counter counts cycles in FETCH or MEM where mem_ready=0. It clears on state entry.
  - When the count reaches TIMEOUT_CYCLES: go to TRAP with cause TRAP_BUS_TIMEOUT, and drop mem_req the following cycle.
- instret wraps modulo 2^32.

## Timing
- Reset (reset high at a clk edge):
  - Next state is FETCH.
  - All outputs are 0 while reset is high: mem_req, ir_we, rf_we, pc_we, pc_sel, mem_we, mem_addr_sel, halted, instret=0, wb_sel=WB_ALU, trap_cause=TRAP_NONE.
  - The first cycle after deassertion drives a fetch request.
- Reset mid-access: mem_req drops with reset. No strobe fires from the interrupted instruction. instret is not incremented.
- Outputs are combinational from state plus registered flags. mem_ready is only sampled while mem_req=1. A mem_ready outside a request is ignored.
- Handshake: once mem_req asserts, it and mem_addr_sel/mem_we stay stable until the mem_ready cycle. The access completes in that same cycle.
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - ALU, branch and jump instructions take 4 cycles.
  - Loads and stores take 5 cycles.
  - Each memory wait cycle adds 1.
- Timeout boundary: with TIMEOUT_CYCLES=N, if mem_ready arrives on wait cycle N, the timeout takes priority and the core traps.

## Structure
- The shared package (defines.svh) gains:
  - ctrl_state_t
  - wb_sel_t
  - trap_cause_t
  - function is_store(ls_op_t), true for i_SB, i_SH, i_SW
- Existing ls_op_t, i_JAL and i_JALR are reused from the package.
- Sub-module mem_timeout: parameterised wait counter with clear, enable and expired ports, width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Reset, then zero-wait ALU instruction (is_alu_op=1):
  - Fetch ir_we at cycle 1, rf_we=1 with wb_sel=WB_ALU at cycle 4, pc_we=1 with pc_sel=0.
  - instret=1.
- Store (i_SW) with 3 memory wait cycles in MEM:
  - mem_addr_sel=1 and mem_we=1 held stable for 4 cycles.
  - WB has rf_we=0. Total 8 cycles.
- JAL (is_br_op=1, br_op=i_JAL, br_taken=1): WB has rf_we=1, wb_sel=WB_PC4, pc_sel=1. BEQ with br_taken=0: rf_we=0, pc_sel=0.
- is_ls_op=1 with ls_op=i_LSNOP:
  - TRAP after EXEC, trap_cause=TRAP_ILLEGAL_LS, halted=1.
  - No further mem_req until reset.
- TIMEOUT_CYCLES=4, mem_ready held low in FETCH:
  - Trap with TRAP_BUS_TIMEOUT after 4 wait cycles; mem_ready on wait cycle 4 still traps.
  - Then assert reset mid-trap: halted=0 and a fetch restarts.
- Retire 2^32−1 preloaded instructions (forced counter), then one more: instret wraps to 0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types for the tiny-riscv core.
//   ls_op_t       load/store opcode from the decoder
//   i_*           branch/jump opcodes carried on br_op
//   ctrl_state_t  sequencer states
//   wb_sel_t      write-back mux select
//   trap_cause_t  reason the core halted
//   is_store()    true for SB/SH/SW
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        i_LSNOP,
        i_LB,
        i_LH,
        i_LW,
        i_LBU,
        i_LHU,
        i_SB,
        i_SH,
        i_SW
    } ls_op_t;

    localparam logic [3:0] i_BRNOP = 4'd0;
    localparam logic [3:0] i_BEQ   = 4'd1;
    localparam logic [3:0] i_BNE   = 4'd2;
    localparam logic [3:0] i_BLT   = 4'd3;
    localparam logic [3:0] i_BGE   = 4'd4;
    localparam logic [3:0] i_BLTU  = 4'd5;
    localparam logic [3:0] i_BGEU  = 4'd6;
    localparam logic [3:0] i_JAL   = 4'd7;
    localparam logic [3:0] i_JALR  = 4'd8;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_t;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ILLEGAL_LS,
        TRAP_BUS_TIMEOUT
    } trap_cause_t;

    function automatic logic is_store(input ls_op_t op);
        return (op == i_SB) || (op == i_SH) || (op == i_SW);
    endfunction

endpackage

// File: rtl/core_ctrl_mem_timeout.sv
// mem_timeout: counts memory wait cycles and flags when the limit is reached.
//   clk, reset  clock, synchronous active-high reset
//   clear       restart the count (state entry)
//   enable      count this cycle (request outstanding, mem_ready low)
//   expired     count has reached TIMEOUT_CYCLES; never set when TIMEOUT_CYCLES is 0
module mem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    // Saturates at LIMIT so a held expiry cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle sequencer owning the shared memory port.
//   clk, reset          clock, synchronous active-high reset
//   mem_req/addr_sel/we memory request, 0=PC 1=ALU address, store enable
//   mem_ready           access complete this cycle
//   ir_we               latch fetched word into IR
//   is_alu_op, is_ls_op, ls_op, is_br_op, br_op, br_taken   decoder/branch inputs
//   rf_we, wb_sel       register-file write strobe and source
//   pc_we, pc_sel       PC update strobe, 0=PC+4 1=target
//   instret             retired-instruction count
//   halted, trap_cause  trap status
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        ir_we,
    input  logic        is_alu_op,
    input  logic        is_ls_op,
    input  ls_op_t      ls_op,
    input  logic        is_br_op,
    input  logic [3:0]  br_op,
    input  logic        br_taken,
    output logic        rf_we,
    output wb_sel_t     wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [31:0] instret,
    output logic        halted,
    output trap_cause_t trap_cause
);

    ctrl_state_t state_q, state_d;
    trap_cause_t cause_q, cause_d;
    logic [31:0] instret_q;
    logic        expired;
    logic        wait_en;
    logic        wait_clear;

    assign wait_en    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign wait_clear = (state_d != state_q);

    mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_en),
        .expired(expired)
    );

    // instret_q is written only in WB so it holds its value in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            cause_q   <= TRAP_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == ST_WB) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Outputs are forced to their idle values while reset is high so an
    // interrupted access drops its request in the reset cycle itself.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        halted       = 1'b0;
        instret      = '0;
        trap_cause   = TRAP_NONE;

        case (state_q)
            ST_FETCH: begin
                // Expiry wins over a mem_ready arriving in the same cycle.
                if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_ls_op) begin
                    if (ls_op == i_LSNOP) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_ILLEGAL_LS;
                    end else begin
                        state_d = ST_MEM;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_BUS_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase

        if (!reset) begin
            instret    = instret_q;
            trap_cause = cause_q;
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready && !expired;
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store(ls_op);
                end
                ST_WB: begin
                    pc_we  = 1'b1;
                    pc_sel = is_br_op && br_taken;
                    if (is_ls_op) begin
                        if (!is_store(ls_op)) begin
                            rf_we  = 1'b1;
                            wb_sel = WB_MEM;
                        end
                    end else if (is_br_op) begin
                        if ((br_op == i_JAL) || (br_op == i_JALR)) begin
                            rf_we  = 1'b1;
                            wb_sel = WB_PC4;
                        end
                    end else if (is_alu_op) begin
                        rf_we  = 1'b1;
                        wb_sel = WB_ALU;
                    end
                end
                ST_TRAP: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
